regfile_mp: RTL

//  Parametrised multi-port integer register file for the next-gen datapath core.
//  NUM_RD combinational read ports, NUM_WR write ports, optional write-to-read bypass.
//  Per-register pending scoreboard: set at instruction issue, cleared at writeback.

---
 rtl/regfile_pkg.sv | 19 +
 rtl/regfile_scoreboard.sv | 65 ++++++
 rtl/regfile_mp.sv | 117 +++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file defaults and scoreboard helpers.
package regfile_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned REG_ZERO   = 0;
    // Widest pending vector the popcount helper accepts (ADDR_W up to 8).
    localparam int unsigned POPCNT_W   = 256;

    function automatic int unsigned popcount(input logic [POPCNT_W-1:0] vec);
        int unsigned total;
        total = 0;
        for (int unsigned i = 0; i < POPCNT_W; i++) begin
            total += int'(vec[i]);
        end
        return total;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending scoreboard: flush > issue > writeback clear, registered count.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned NUM_WR   = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rdAddr,
    input  logic [NUM_WR-1:0]        wrEn,
    input  logic [NUM_WR*ADDR_W-1:0] wrAddr,
    input  logic                     issueEn,
    input  logic [ADDR_W-1:0]        issueAddr,
    input  logic                     flush,
    output logic [NUM_RD-1:0]        rdBusy,
    output logic [ADDR_W:0]          pendingCnt
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [DEPTH-1:0] pend;
    logic [DEPTH-1:0] pendNext;

    always_comb begin
        pendNext = pend;
        if (flush) begin
            pendNext = '0;
        end else begin
            for (int unsigned w = 0; w < NUM_WR; w++) begin
                if (wrEn[w]) begin
                    pendNext[wrAddr[w*ADDR_W +: ADDR_W]] = 1'b0;
                end
            end
            // Issue is applied after the clears so it wins over a same-cycle writeback.
            if (issueEn) begin
                pendNext[issueAddr] = 1'b1;
            end
        end
        if (ZERO_REG != 0) begin
            pendNext[REG_ZERO] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend       <= '0;
            pendingCnt <= '0;
        end else begin
            pend       <= pendNext;
            pendingCnt <= CNT_W'(popcount(POPCNT_W'(pendNext)));
        end
    end

    always_comb begin
        rdBusy = '0;
        for (int unsigned p = 0; p < NUM_RD; p++) begin
            rdBusy[p] = pend[rdAddr[p*ADDR_W +: ADDR_W]];
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: storage, write arbitration, write-to-read bypass.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned NUM_WR   = 2,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     issue_en,
    input  logic [ADDR_W-1:0]        issue_addr,
    input  logic                     flush,
    output logic [ADDR_W:0]          pending_cnt
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    if (NUM_RD < 1 || NUM_RD > 4) begin : g_badNumRd
        $error("regfile_mp: NUM_RD must be 1..4");
    end
    if (NUM_WR < 1 || NUM_WR > 2) begin : g_badNumWr
        $error("regfile_mp: NUM_WR must be 1..2");
    end
    if (ADDR_W < 1 || ADDR_W > 8 || DATA_W < 1) begin : g_badWidth
        $error("regfile_mp: ADDR_W must be 1..8 and DATA_W at least 1");
    end
    if (ZERO_REG > 1 || BYPASS > 1) begin : g_badFlag
        $error("regfile_mp: ZERO_REG and BYPASS must be 0 or 1");
    end

    logic [DATA_W-1:0] mem [DEPTH];
    logic [NUM_WR-1:0] wrEnEff;
    logic [NUM_RD-1:0] sbBusy;
    logic [NUM_RD-1:0] bypassHit;
    logic [NUM_RD-1:0] zeroRead;

    always_comb begin
        wrEnEff = '0;
        for (int unsigned w = 0; w < NUM_WR; w++) begin
            wrEnEff[w] = wr_en[w] &&
                !(ZERO_REG != 0 && wr_addr[w*ADDR_W +: ADDR_W] == ADDR_W'(REG_ZERO));
        end
    end

    // Later ports are assigned last, so the highest-index port wins a same-address collision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int unsigned w = 0; w < NUM_WR; w++) begin
                if (wrEnEff[w]) begin
                    mem[wr_addr[w*ADDR_W +: ADDR_W]] <= wr_data[w*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_comb begin
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        rd_data   = '0;
        bypassHit = '0;
        zeroRead  = '0;
        addr      = '0;
        data      = '0;
        for (int unsigned p = 0; p < NUM_RD; p++) begin
            addr = rd_addr[p*ADDR_W +: ADDR_W];
            data = mem[addr];
            if (BYPASS != 0) begin
                for (int unsigned w = 0; w < NUM_WR; w++) begin
                    if (wrEnEff[w] && wr_addr[w*ADDR_W +: ADDR_W] == addr) begin
                        bypassHit[p] = 1'b1;
                        data         = wr_data[w*DATA_W +: DATA_W];
                    end
                end
            end
            if (ZERO_REG != 0 && addr == ADDR_W'(REG_ZERO)) begin
                zeroRead[p] = 1'b1;
                data        = '0;
            end
            rd_data[p*DATA_W +: DATA_W] = data;
        end
    end

    assign rd_busy = sbBusy & ~bypassHit & ~zeroRead;

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .NUM_WR   (NUM_WR),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .rdAddr     (rd_addr),
        .wrEn       (wrEnEff),
        .wrAddr     (wr_addr),
        .issueEn    (issue_en),
        .issueAddr  (issue_addr),
        .flush      (flush),
        .rdBusy     (sbBusy),
        .pendingCnt (pending_cnt)
    );

endmodule
